corelet_seq: RTL

Parametrised, self-sequencing successor to the hand-driven corelet control path. It runs an N-pass weight-stationary (WS) or output-stationary (OS) job from a single `start`. It issues the L0/IFIFO read, load/execute and OFIFO pop strobes itself, and reduces every drained psum vector into a saturating per-column accumulator bank with optional ReLU. It sits between the top-level controller and the L0 / IFIFO / MAC array / OFIFO of one core, replacing the external cycle-by-cycle instruction stream.

---
 rtl/corelet_seq.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/corelet_seq.sv
// corelet_seq: self-sequencing WS/OS control path for one core, with a
// saturating per-column psum accumulator bank and optional ReLU on the result.
module corelet_seq #(
   parameter int unsigned row     = 8,
   parameter int unsigned col     = 8,
   parameter int unsigned psum_bw = 16,
   parameter int unsigned cnt_w   = 10
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   input  logic                   os_mode,
   input  logic                   relu_en,
   input  logic [cnt_w-1:0]       n_load,
   input  logic [cnt_w-1:0]       n_exec,
   input  logic [3:0]             n_pass,
   input  logic                   l0_ready,
   input  logic                   ififo_ready,
   input  logic                   ofifo_valid,
   input  logic [col*psum_bw-1:0] psum_in,
   output logic                   l0_rd,
   output logic                   ififo_rd,
   output logic                   load,
   output logic                   execute,
   output logic                   ofifo_rd,
   output logic                   busy,
   output logic                   done,
   output logic [col*psum_bw-1:0] out,
   output logic                   out_valid,
   output logic                   err_ovf
);

   localparam int unsigned      AW       = psum_bw + 1;
   localparam logic [cnt_w-1:0] GAP_LAST = cnt_w'(row + col - 2);
   localparam logic [cnt_w-1:0] ROW_CNT  = cnt_w'(row);
   localparam logic [cnt_w-1:0] ONE      = cnt_w'(1);

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_GAP, S_EXEC, S_DRAIN, S_OUT} state_t;

   state_t                      state_q, state_d;
   logic [cnt_w-1:0]            cnt_q, cnt_d;
   logic [cnt_w-1:0]            n_load_q, n_load_d, n_exec_q, n_exec_d;
   logic [3:0]                  n_pass_q, n_pass_d, pass_q, pass_d;
   logic                        os_q, os_d, relu_q, relu_d;
   logic                        err_q, err_d, busy_q, busy_d, done_q, done_d;
   logic [col-1:0][psum_bw-1:0] acc_q, acc_d, out_q, out_d;
   logic [col-1:0][AW-1:0]      sum_c;

   logic                        idle_c, c_os, more_pass_c, phase_end_c, pass_end_c;
   logic [cnt_w-1:0]            c_nload, c_nexec, drain_tgt_c;
   logic [3:0]                  c_npass, pass_last_c;
   state_t                      pass_start_st_c, after_pass_st_c, after_exec_st_c;

   // In IDLE the job is described by the live inputs, afterwards by the latched copy.
   always_comb begin
      idle_c          = (state_q == S_IDLE);
      c_os            = idle_c ? os_mode : os_q;
      c_nload         = idle_c ? n_load  : n_load_q;
      c_nexec         = idle_c ? n_exec  : n_exec_q;
      c_npass         = idle_c ? n_pass  : n_pass_q;
      pass_last_c     = (c_npass == 4'd0) ? 4'd0 : c_npass - 4'd1;
      more_pass_c     = (pass_q < pass_last_c);
      drain_tgt_c     = c_os ? ROW_CNT : c_nexec;
      // Empty phases are skipped so that zero-length LOAD/EXEC/DRAIN cost no cycles.
      pass_start_st_c = c_os ? ((c_nexec == '0) ? S_DRAIN : S_EXEC)
                             : ((c_nload == '0) ? S_GAP   : S_LOAD);
      after_pass_st_c = more_pass_c ? pass_start_st_c : S_OUT;
      after_exec_st_c = (!c_os && c_nexec == '0) ? after_pass_st_c : S_DRAIN;
   end

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   // Next-state logic.
   always_comb begin
      state_d     = state_q;
      phase_end_c = 1'b0;
      pass_end_c  = 1'b0;
      unique case (state_q)
         S_IDLE: if (start) begin
            state_d     = pass_start_st_c;
            phase_end_c = 1'b1;
         end
         S_LOAD: if (load && cnt_q == c_nload - ONE) begin
            state_d     = S_GAP;
            phase_end_c = 1'b1;
         end
         S_GAP: if (cnt_q == GAP_LAST) begin
            state_d     = (c_nexec == '0) ? after_exec_st_c : S_EXEC;
            phase_end_c = 1'b1;
            pass_end_c  = (c_nexec == '0);
         end
         S_EXEC: if (execute && cnt_q == c_nexec - ONE) begin
            state_d     = S_DRAIN;
            phase_end_c = 1'b1;
         end
         S_DRAIN: if (ofifo_rd && cnt_q == drain_tgt_c - ONE) begin
            state_d     = after_pass_st_c;
            phase_end_c = 1'b1;
            pass_end_c  = 1'b1;
         end
         S_OUT:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Strobe decode: combinational from registered state for zero-bubble issue.
   always_comb begin
      load     = 1'b0;
      l0_rd    = 1'b0;
      execute  = 1'b0;
      ififo_rd = 1'b0;
      ofifo_rd = 1'b0;
      case (state_q)
         S_LOAD: begin
            load  = l0_ready;
            l0_rd = l0_ready;
         end
         S_EXEC: begin
            execute  = l0_ready & (ififo_ready | ~os_q);
            l0_rd    = execute;
            ififo_rd = execute & os_q;
         end
         S_DRAIN: ofifo_rd = ofifo_valid;
         default: ;
      endcase
   end

   // Counters, config latch, accumulator bank and registered outputs.
   always_comb begin
      cnt_d    = cnt_q;
      pass_d   = pass_q;
      os_d     = os_q;
      relu_d   = relu_q;
      n_load_d = n_load_q;
      n_exec_d = n_exec_q;
      n_pass_d = n_pass_q;
      err_d    = err_q;
      acc_d    = acc_q;
      sum_c    = '0;

      if (phase_end_c)
         cnt_d = '0;
      else if (load | execute | ofifo_rd | (state_q == S_GAP))
         cnt_d = cnt_q + ONE;

      if (idle_c && start) begin
         os_d     = os_mode;
         relu_d   = relu_en;
         n_load_d = n_load;
         n_exec_d = n_exec;
         n_pass_d = n_pass;
         pass_d   = '0;
         err_d    = 1'b0;
         acc_d    = '0;
      end

      if (pass_end_c && more_pass_c)
         pass_d = pass_q + 4'd1;

      for (int c = 0; c < col; c++) begin
         sum_c[c] = {acc_q[c][psum_bw-1], acc_q[c]}
                  + {psum_in[c*psum_bw + psum_bw - 1], psum_in[c*psum_bw +: psum_bw]};
         if (ofifo_rd) begin
            if (sum_c[c][AW-1] != sum_c[c][AW-2]) begin
               acc_d[c] = sum_c[c][AW-1] ? {1'b1, {(psum_bw-1){1'b0}}}
                                         : {1'b0, {(psum_bw-1){1'b1}}};
               err_d    = 1'b1;
            end else begin
               acc_d[c] = sum_c[c][psum_bw-1:0];
            end
         end
      end

      busy_d = (state_d != S_IDLE);
      done_d = (state_d == S_OUT);
      for (int c = 0; c < col; c++)
         out_d[c] = (done_d && !(relu_q && acc_d[c][psum_bw-1])) ? acc_d[c] : '0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q    <= '0;
         pass_q   <= '0;
         os_q     <= 1'b0;
         relu_q   <= 1'b0;
         n_load_q <= '0;
         n_exec_q <= '0;
         n_pass_q <= '0;
         err_q    <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         acc_q    <= '0;
         out_q    <= '0;
      end else begin
         cnt_q    <= cnt_d;
         pass_q   <= pass_d;
         os_q     <= os_d;
         relu_q   <= relu_d;
         n_load_q <= n_load_d;
         n_exec_q <= n_exec_d;
         n_pass_q <= n_pass_d;
         err_q    <= err_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         acc_q    <= acc_d;
         out_q    <= out_d;
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign out_valid = done_q;
   assign out       = out_q;
   assign err_ovf   = err_q;

endmodule
